countdown_timer: RTL

//   Loadable down-counter/timer; the counterpart of the free-running up counter.

---
 rtl/countdown_timer_if.sv | 31 +++
 rtl/countdown_timer.sv | 82 ++++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Control/status bundle for countdown_timer.
//   master: the controlling FSM. It drives load_val, start and stop, and observes cntr, busy and done.
//   slave : the timer itself. Its signal directions are the reverse of master.
//   Signals:
//     load_val  CNTR_WIDTH  start value, sampled only when a start is accepted
//     start     1           start/restart request, level-sampled every cycle
//     stop      1           abort request, level-sampled every cycle
//     cntr      CNTR_WIDTH  current count (registered)
//     busy      1           timer is running
//     done      1           one-cycle terminal-count pulse (registered)
interface countdown_timer_if #(
    parameter int CNTR_WIDTH = 4
);
    logic [CNTR_WIDTH-1:0] load_val;
    logic                  start;
    logic                  stop;
    logic [CNTR_WIDTH-1:0] cntr;
    logic                  busy;
    logic                  done;

    modport master (
        output load_val, start, stop,
        input  cntr, busy, done
    );

    modport slave (
        input  load_val, start, stop,
        output cntr, busy, done
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter. A start loads load_val. The counter then counts down to zero.
//   One cycle after the count reaches zero, the timer emits a one-cycle done pulse.
//   What happens next depends on AUTO_RELOAD:
//     - one-shot: the timer returns to idle.
//     - periodic: the timer reloads the captured start value.
//   Edge priority: stop > start > terminal count > decrement.
//   Ports:
//     clk    clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    countdown_timer_if slave modport (load_val/start/stop in; cntr/busy/done out)
//   Parameters:
//     CNTR_WIDTH   width of load_val and cntr
//     AUTO_RELOAD  0 = one-shot, 1 = periodic
module countdown_timer #(
    parameter int CNTR_WIDTH  = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    countdown_timer_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [CNTR_WIDTH-1:0] cntr_q;
    logic [CNTR_WIDTH-1:0] reload_q;
    logic                  done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cntr_q   <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // done is a single-cycle pulse.
            // Only the terminal branch below re-asserts it.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A simultaneous stop vetoes the start, so nothing is loaded.
                    if (bus.start && !bus.stop) begin
                        cntr_q   <= bus.load_val;
                        reload_q <= bus.load_val;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        // Abort: cntr freezes and no done pulse is produced.
                        state <= IDLE;
                    end else if (bus.start) begin
                        // Restart wins over the terminal count, so no done pulse.
                        cntr_q   <= bus.load_val;
                        reload_q <= bus.load_val;
                    end else if (cntr_q == '0) begin
                        done_q <= 1'b1;
                        if (AUTO_RELOAD) begin
                            cntr_q <= reload_q;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        // Zero is terminal, so this never wraps.
                        cntr_q <= cntr_q - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cntr = cntr_q;
    assign bus.busy = (state == RUN);
    assign bus.done = done_q;

endmodule
